// File: rtl/expr_pkg.sv
// Shared constants and encodings for the ASCII expression evaluator.
package expr_pkg;

    localparam logic [7:0] CH_0   = 8'h30;
    localparam logic [7:0] CH_9   = 8'h39;
    localparam logic [7:0] CH_ADD = 8'h2B;
    localparam logic [7:0] CH_MUL = 8'h2A;
    localparam logic [7:0] CH_EQ  = 8'h3D;
    localparam logic [7:0] CH_SP  = 8'h20;

    typedef enum logic [2:0] {
        ClsDig,
        ClsAdd,
        ClsMul,
        ClsEq,
        ClsSp,
        ClsOther
    } char_cls_e;

    typedef enum logic [1:0] {
        StExpDig,
        StExpOp,
        StDrain,
        StResult
    } state_e;

endpackage

// File: rtl/expr_char_class.sv
// Combinational classifier: ASCII character to character class plus digit value.
module expr_char_class
    import expr_pkg::*;
(
    input  logic [7:0] ch_i,
    output logic [2:0] cls_o,
    output logic [3:0] digit_o
);

    always_comb begin
        digit_o = ch_i[3:0];
        cls_o   = ClsOther;
        if (ch_i >= CH_0 && ch_i <= CH_9) begin
            cls_o = ClsDig;
        end else begin
            case (ch_i)
                CH_ADD:  cls_o = ClsAdd;
                CH_MUL:  cls_o = ClsMul;
                CH_EQ:   cls_o = ClsEq;
                CH_SP:   cls_o = ClsSp;
                default: cls_o = ClsOther;
            endcase
        end
    end

endmodule

// File: rtl/expr_eval_ctrl.sv
// Streaming evaluator for "digit (op digit)* =" expressions with '*' above '+'.
module expr_eval_ctrl
    import expr_pkg::*;
#(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         clr_n,
    input  logic         in_valid,
    input  logic [7:0]   in_data,
    output logic         in_ready,
    output logic         res_valid,
    output logic [W-1:0] res_data,
    output logic         res_err,
    output logic         res_ovf,
    input  logic         res_ready,
    output logic         expr_ok
);

    logic [2:0] cls_raw;
    logic [3:0] digit;
    char_cls_e  cls;

    expr_char_class u_class (
        .ch_i    (in_data),
        .cls_o   (cls_raw),
        .digit_o (digit)
    );

    assign cls = char_cls_e'(cls_raw);

    state_e       state_q, state_d;
    logic [W-1:0] sum_q, sum_d, term_q, term_d;
    logic         mul_q, mul_d, ovf_q, ovf_d;
    logic         res_valid_q, res_valid_d, res_err_q, res_err_d, res_ovf_q, res_ovf_d;
    logic [W-1:0] res_data_q, res_data_d;

    // Full-width intermediates; any nonzero upper half means the W-bit value wrapped.
    logic [2*W-1:0] prod_w, sum_w;
    logic [W-1:0]   dig_term;
    logic           dig_ovf, sum_ovf, accept;

    assign prod_w   = {{W{1'b0}}, term_q} * {{(2*W-4){1'b0}}, digit};
    assign sum_w    = {{W{1'b0}}, sum_q} + {{W{1'b0}}, term_q};
    assign dig_term = mul_q ? prod_w[W-1:0] : {{(W-4){1'b0}}, digit};
    assign dig_ovf  = mul_q & (|prod_w[2*W-1:W]);
    assign sum_ovf  = |sum_w[2*W-1:W];
    assign accept   = in_valid & in_ready;

    always_comb begin
        state_d     = state_q;
        sum_d       = sum_q;
        term_d      = term_q;
        mul_d       = mul_q;
        ovf_d       = ovf_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_err_d   = res_err_q;
        res_ovf_d   = res_ovf_q;

        if (accept && cls != ClsSp) begin
            unique case (state_q)
                StExpDig: begin
                    if (cls == ClsDig) begin
                        term_d  = dig_term;
                        ovf_d   = ovf_q | dig_ovf;
                        mul_d   = 1'b0;
                        state_d = StExpOp;
                    end else if (cls == ClsEq) begin
                        res_valid_d = 1'b1;
                        res_data_d  = '0;
                        res_err_d   = 1'b1;
                        res_ovf_d   = ovf_q;
                        state_d     = StResult;
                    end else begin
                        state_d = StDrain;
                    end
                end
                StExpOp: begin
                    case (cls)
                        ClsAdd: begin
                            sum_d   = sum_w[W-1:0];
                            ovf_d   = ovf_q | sum_ovf;
                            state_d = StExpDig;
                        end
                        ClsMul: begin
                            mul_d   = 1'b1;
                            state_d = StExpDig;
                        end
                        ClsEq: begin
                            res_valid_d = 1'b1;
                            res_data_d  = sum_w[W-1:0];
                            res_err_d   = 1'b0;
                            res_ovf_d   = ovf_q | sum_ovf;
                            state_d     = StResult;
                        end
                        default: state_d = StDrain;
                    endcase
                end
                StDrain: begin
                    if (cls == ClsEq) begin
                        res_valid_d = 1'b1;
                        res_data_d  = '0;
                        res_err_d   = 1'b1;
                        res_ovf_d   = ovf_q;
                        state_d     = StResult;
                    end
                end
                StResult: ;
            endcase
        end

        if (state_q == StResult && res_ready) begin
            sum_d       = '0;
            term_d      = '0;
            mul_d       = 1'b0;
            ovf_d       = 1'b0;
            res_valid_d = 1'b0;
            state_d     = StExpDig;
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q     <= StExpDig;
            sum_q       <= '0;
            term_q      <= '0;
            mul_q       <= 1'b0;
            ovf_q       <= 1'b0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_err_q   <= 1'b0;
            res_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            sum_q       <= sum_d;
            term_q      <= term_d;
            mul_q       <= mul_d;
            ovf_q       <= ovf_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_err_q   <= res_err_d;
            res_ovf_q   <= res_ovf_d;
        end
    end

    assign in_ready  = (state_q != StResult);
    assign expr_ok   = (state_q == StExpOp);
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_err   = res_err_q;
    assign res_ovf   = res_ovf_q;

endmodule

// File: tb/tb_expr_eval_ctrl.sv
// Bench for expr_eval_ctrl: directed cases plus random expressions against a string-level model.
module tb_expr_eval_ctrl;

    localparam int W = 16;
    localparam longint LIM = 64'd1 << W;

    typedef logic [7:0] ch_t;

    logic         clk = 1'b0;
    logic         clr_n = 1'b1;
    logic         in_valid = 1'b0;
    logic [7:0]   in_data = 8'h00;
    logic         res_ready = 1'b0;
    logic         in_ready, res_valid, res_err, res_ovf, expr_ok;
    logic [W-1:0] res_data;

    expr_eval_ctrl #(.W(W)) dut (
        .clk       (clk),
        .clr_n     (clr_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .res_valid (res_valid),
        .res_data  (res_data),
        .res_err   (res_err),
        .res_ovf   (res_ovf),
        .res_ready (res_ready),
        .expr_ok   (expr_ok)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    bit rr_random = 1'b0;
    bit rr_hold = 1'b1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out at %0t", name, $time);
    endtask

    // ---------------- reference model (string level) ----------------
    ch_t          buf_q[$];
    bit           m_pending = 1'b0;
    bit           m_ok = 1'b0;
    bit           m_err = 1'b0;
    bit           m_ovf = 1'b0;
    logic [W-1:0] m_data = '0;

    function automatic bit is_dig(input ch_t c);
        return c >= 8'h30 && c <= 8'h39;
    endfunction

    // A complete expression alternates digit, operator, ..., digit.
    function automatic bit complete(input ch_t b[$]);
        if (b.size() % 2 == 0) return 1'b0;
        for (int i = 0; i < b.size(); i++) begin
            if (i % 2 == 0 && !is_dig(b[i])) return 1'b0;
            if (i % 2 == 1 && b[i] != 8'h2B && b[i] != 8'h2A) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic void evaluate(input ch_t b[$], output logic [W-1:0] data,
                                     output bit err, output bit ovf);
        longint sum = 0;
        longint term = 0;
        bit mul = 1'b0;
        int i = 0;
        longint d;
        err = 1'b0;
        ovf = 1'b0;
        data = '0;
        while (1) begin
            if (i >= b.size() || !is_dig(b[i])) begin
                err = 1'b1;
                break;
            end
            d = longint'(b[i]) - 48;
            if (mul) begin
                term = term * d;
                if (term >= LIM) begin ovf = 1'b1; term = term % LIM; end
            end else begin
                term = d;
            end
            mul = 1'b0;
            i++;
            if (i == b.size()) begin
                sum = sum + term;
                if (sum >= LIM) begin ovf = 1'b1; sum = sum % LIM; end
                data = W'(sum);
                break;
            end
            if (b[i] == 8'h2B) begin
                sum = sum + term;
                if (sum >= LIM) begin ovf = 1'b1; sum = sum % LIM; end
            end else if (b[i] == 8'h2A) begin
                mul = 1'b1;
            end else begin
                err = 1'b1;
                break;
            end
            i++;
        end
    endfunction

    always @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            buf_q.delete();
            m_pending = 1'b0;
            m_ok = 1'b0;
        end else if (m_pending) begin
            if (res_ready) m_pending = 1'b0;
        end else if (in_valid) begin
            if (in_data == 8'h3D) begin
                evaluate(buf_q, m_data, m_err, m_ovf);
                m_pending = 1'b1;
                m_ok = 1'b0;
                buf_q.delete();
            end else if (in_data != 8'h20) begin
                buf_q.push_back(in_data);
                m_ok = complete(buf_q);
            end
        end
    end

    always @(negedge clk) begin
        if (clr_n) begin
            check("in_ready", in_ready, !m_pending);
            check("expr_ok", expr_ok, m_ok);
            check("res_valid", res_valid, m_pending);
            if (m_pending) begin
                check("res_data", res_data, m_err ? '0 : m_data);
                check("res_err", res_err, m_err);
                check("res_ovf", res_ovf, m_ovf);
            end
        end
    end

    // ---------------- driver ----------------
    task automatic tick();
        @(negedge clk);
        in_valid = 1'b0;
        in_data = 8'($urandom);
        res_ready = rr_random ? 1'($urandom % 2) : rr_hold;
    endtask

    task automatic send_char(input ch_t c);
        int n = 0;
        tick();
        if (rr_random && $urandom % 4 == 0) tick();
        while (!in_ready && n < 100) begin
            tick();
            n++;
        end
        if (!in_ready) begin
            fail_now("in_ready_wait");
            return;
        end
        in_valid = 1'b1;
        in_data = c;
        @(posedge clk);
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_char(s[i]);
    endtask

    task automatic wait_result(input string name, input int exp_data, input bit exp_err,
                               input bit exp_ovf);
        for (int n = 0; n < 30; n++) begin
            tick();
            if (res_valid) begin
                check({name, "_data"}, res_data, 64'(exp_data));
                check({name, "_err"}, res_err, exp_err);
                check({name, "_ovf"}, res_ovf, exp_ovf);
                return;
            end
        end
        fail_now({name, "_result"});
    endtask

    task automatic send_random_expr();
        string pool = " +*=7xA9";
        int n = $urandom_range(1, 6);
        bit heavy = ($urandom % 4 == 0);
        ch_t c;
        for (int j = 0; j < n; j++) begin
            if ($urandom % 12 == 0) send_char(pool[$urandom % pool.len()]);
            if ($urandom % 40 == 0) send_char(8'($urandom));
            c = heavy ? 8'h39 : 8'(8'h30 + $urandom_range(0, 9));
            send_char(c);
            if (j < n - 1 || $urandom % 8 == 0) send_char(($urandom % 2) ? 8'h2B : 8'h2A);
        end
        send_char(8'h3D);
    endtask

    initial begin
        #1 clr_n = 1'b0;
        #3;
        check("rst_res_valid", res_valid, 1'b0);
        check("rst_res_data", res_data, '0);
        check("rst_res_err", res_err, 1'b0);
        check("rst_res_ovf", res_ovf, 1'b0);
        check("rst_expr_ok", expr_ok, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);
        tick();
        tick();
        clr_n = 1'b1;

        // 1: precedence and expr_ok after digit / operator
        send_char("1");
        tick();
        check("t1_ok_after_digit", expr_ok, 1'b1);
        send_char("+");
        tick();
        check("t1_ok_after_op", expr_ok, 1'b0);
        send_str("2*3+4=");
        wait_result("t1", 11, 1'b0, 1'b0);

        // 2: two results back to back
        send_str("1+2+3=");
        wait_result("t2a", 6, 1'b0, 1'b0);
        send_str("2*3*4=");
        wait_result("t2b", 24, 1'b0, 1'b0);

        // 3: wrapping product chain
        send_str("9*9*9*9*9*9=");
        wait_result("t3", 7153, 1'b0, 1'b1);

        // 4: grammar errors, then spaces
        send_str("1++2=");
        wait_result("t4a", 0, 1'b1, 1'b0);
        send_str("12=");
        wait_result("t4b", 0, 1'b1, 1'b0);
        send_str(" 5 =");
        wait_result("t4c", 5, 1'b0, 1'b0);

        // 5: lone '=' and a stalled consumer
        send_str("=");
        wait_result("t5a", 0, 1'b1, 1'b0);
        rr_hold = 1'b0;
        send_str("7=");
        for (int k = 0; k < 3; k++) begin
            tick();
            check("t5_hold_valid", res_valid, 1'b1);
            check("t5_hold_data", res_data, 64'd7);
            check("t5_hold_in_ready", in_ready, 1'b0);
        end
        rr_hold = 1'b1;
        wait_result("t5b", 7, 1'b0, 1'b0);
        tick();
        check("t5_consumed", res_valid, 1'b0);

        // 6: reset in the middle of an expression
        send_str("3*");
        @(negedge clk);
        in_valid = 1'b0;
        #1 clr_n = 1'b0;
        #2 clr_n = 1'b1;
        tick();
        check("t6_no_result", res_valid, 1'b0);
        check("t6_ok_cleared", expr_ok, 1'b0);
        send_str("4=");
        wait_result("t6", 4, 1'b0, 1'b0);

        // random traffic with random consumer back-pressure
        rr_random = 1'b1;
        for (int e = 0; e < 300; e++) send_random_expr();
        rr_random = 1'b0;
        rr_hold = 1'b1;
        for (int k = 0; k < 10; k++) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
